memory_access: RTL and testbench
================================

# memory_access

Memory stage of the five-stage MIPS pipeline: sits between the EX/MEM pipeline register and the MEM/WB pipeline register, and consumes the register-writeback triple (destination, write enable, write data) plus memory-op fields produced by the execute stage. Non-memory instructions pass straight through. Loads and stores run a req/ack handshake with the data memory, freeze the pipeline through `stall_o`, and return sign/zero-extended load data as the writeback value.

## Interface
Parameters: none.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `dest_addr_i`  in  5  destination register from EX/MEM
- `write_or_not_i`  in  1  register write enable from EX/MEM
- `wdata_i`  in  32  ALU result from EX/MEM
- `mem_op_i`  in  4  memory operation: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- `mem_addr_i`  in  32  effective byte address
- `mem_sdata_i`  in  32  store data, right-justified
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  1 = store
- `mem_addr_o`  out  32  word address, `{mem_addr_i[31:2], 2'b00}`
- `mem_be_o`  out  4  byte enables, bit 3 = bits 31:24
- `mem_wdata_o`  out  32  lane-replicated store data
- `mem_rdata_i`  in  32  read data, valid when `mem_ack_i` = 1
- `mem_ack_i`  in  1  completes the request
- `dest_addr_o`  out  5  to MEM/WB
- `write_or_not_o`  out  1  to MEM/WB
- `wdata_o`  out  32  to MEM/WB
- `stall_o`  out  1  freeze IF..EX/MEM
- `misalign_o`  out  1  misaligned access flagged this cycle

## Operation
- Byte lanes are big-endian: address offset 0 → bits 31:24, offset 3 → bits 7:0.
- Alignment:
  - LH/LHU/SH require `addr[0]` = 0.
  - LW/SW require `addr[1:0]` = 0.
  - A misaligned op sets `misalign_o` = 1 and `write_or_not_o` = 0. It raises no request and no stall, and completes in one cycle.
- Store data and enables:
  - SB: byte replicated ×4; `be` = one-hot lane.
  - SH: half replicated ×2; `be` = 1100 (offset 0) or 0011 (offset 2).
  - SW: `be` = 1111.
- Loads: the selected lane is extracted and right-justified. LB and LH sign-extend; LBU and LHU zero-extend; LW takes the full word.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Non-memory op (or misaligned): outputs equal the inputs combinationally; `stall_o` = 0.
  - Aligned memory op: `stall_o` = 1; next state ACCESS.
- ACCESS:
  - `mem_req_o` = 1 and `stall_o` = 1.
  - `mem_addr_o`, `mem_we_o`, `mem_be_o` and `mem_wdata_o` are held stable.
  - On `mem_ack_i` = 1: the extended load result is registered into `ld_data`; next state DONE.
- DONE:
  - `stall_o` = 0 and `mem_req_o` = 0.
  - Loads: `wdata_o` = `ld_data`, `write_or_not_o` = `write_or_not_i`.
  - Stores: `write_or_not_o` = 0.
  - Next state IDLE unconditionally. DONE never re-triggers on the same instruction.
- Upstream holds all `_i` inputs constant while `stall_o` = 1.

## Timing
- Reset: state = IDLE, `ld_data` = 0. While `rst` = 1, `mem_req_o`, `stall_o` and `misalign_o` are forced to 0.
- Reset mid-ACCESS: the request is abandoned, `mem_req_o` = 0 the cycle after the reset edge, and a late ack in IDLE is ignored.
- Pass-through: 0 cycles, combinational.
- Memory op with ack in the first ACCESS cycle: stall asserted for 2 cycles (IDLE, ACCESS). The result is presented in DONE, the 3rd cycle. Each extra wait cycle adds 1.
- `mem_ack_i` is ignored outside ACCESS.
- Back-to-back memory ops: DONE → IDLE → ACCESS, giving a minimum of 3 cycles per op.

## Test plan
- ALU pass-through: `mem_op` = 0, dest = 5, we = 1, wdata = 0x1234 → same-cycle outputs 5/1/0x1234; `stall_o` = 0; no request.
- LW: addr 0x100, ack after 2 wait cycles, rdata 0xDEADBEEF → `mem_addr_o` = 0x100 with `be` = 1111; stall for 4 cycles; in DONE `wdata_o` = 0xDEADBEEF, we = 1.
- LB vs LBU: addr 0x103, rdata 0x000000F0 → LB gives 0xFFFFFFF0; LBU gives 0x000000F0.
- SH: addr 0x202, sdata 0xABCD1234 → `mem_addr_o` = 0x200, `be` = 0011, wdata = 0x12341234, `we_o` = 1; `write_or_not_o` = 0 in DONE.
- Misaligned LW at 0x101 → `misalign_o` = 1, no `mem_req_o`, `stall_o` = 0, `write_or_not_o` = 0.
- `rst` pulsed during ACCESS → next cycle IDLE with `mem_req_o` = 0 and `stall_o` = 0; a subsequent ack is ignored and `ld_data` = 0.

Source files
------------

// File: rtl/memory_access.sv
// MIPS pipeline memory stage: ALU results pass straight through; loads and stores
// run a req/ack handshake with data memory while stalling the upstream stages.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  dest_addr_i,
    input  logic        write_or_not_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_sdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [4:0]  dest_addr_o,
    output logic        write_or_not_o,
    output logic [31:0] wdata_o,
    output logic        stall_o,
    output logic        misalign_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    logic [1:0]  state, state_next;
    logic [31:0] ld_data;
    logic [31:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [1:0]  offset;
    logic        is_load, is_store, is_mem, aligned;

    assign offset   = mem_addr_i[1:0];
    assign is_load  = (mem_op_i >= OP_LB) && (mem_op_i <= OP_LW);
    assign is_store = (mem_op_i >= OP_SB) && (mem_op_i <= OP_SW);
    assign is_mem   = is_load || is_store;

    always_comb begin
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: aligned = (offset[0] == 1'b0);
            OP_LW, OP_SW:         aligned = (offset == 2'b00);
            default:              aligned = 1'b1;
        endcase
    end

    // Request fields derive from the held inputs, so they stay stable across ACCESS.
    assign mem_addr_o = {mem_addr_i[31:2], 2'b00};
    assign mem_we_o   = is_store;

    always_comb begin
        mem_be_o    = '0;
        mem_wdata_o = '0;
        case (mem_op_i)
            OP_LB, OP_LBU, OP_SB: begin
                mem_be_o    = 4'b1000 >> offset;
                mem_wdata_o = {4{mem_sdata_i[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                mem_be_o    = offset[1] ? 4'b0011 : 4'b1100;
                mem_wdata_o = {2{mem_sdata_i[15:0]}};
            end
            OP_LW, OP_SW: begin
                mem_be_o    = 4'b1111;
                mem_wdata_o = mem_sdata_i;
            end
            default: ;
        endcase
    end

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        case (offset)
            2'd0:    ld_byte = mem_rdata_i[31:24];
            2'd1:    ld_byte = mem_rdata_i[23:16];
            2'd2:    ld_byte = mem_rdata_i[15:8];
            default: ld_byte = mem_rdata_i[7:0];
        endcase
        ld_half = offset[1] ? mem_rdata_i[15:0] : mem_rdata_i[31:16];
        case (mem_op_i)
            OP_LB:   ld_ext = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_ext = {24'h0, ld_byte};
            OP_LH:   ld_ext = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_ext = {16'h0, ld_half};
            default: ld_ext = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_next     = state;
        mem_req_o      = 1'b0;
        stall_o        = 1'b0;
        misalign_o     = 1'b0;
        dest_addr_o    = dest_addr_i;
        write_or_not_o = write_or_not_i;
        wdata_o        = wdata_i;
        case (state)
            IDLE: begin
                if (is_mem && !aligned) begin
                    misalign_o     = 1'b1;
                    write_or_not_o = 1'b0;
                end else if (is_mem) begin
                    stall_o        = 1'b1;
                    write_or_not_o = 1'b0;
                    state_next     = ACCESS;
                end
            end
            ACCESS: begin
                mem_req_o      = 1'b1;
                stall_o        = 1'b1;
                write_or_not_o = 1'b0;
                if (mem_ack_i) state_next = DONE;
            end
            DONE: begin
                if (is_load) wdata_o = ld_data;
                else if (is_store) write_or_not_o = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            mem_req_o  = 1'b0;
            stall_o    = 1'b0;
            misalign_o = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ld_data <= '0;
        end else begin
            state <= state_next;
            if (state == ACCESS && mem_ack_i) ld_data <= ld_ext;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: pass-through, loads, stores, misalignment
// and reset abandoning an in-flight request.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  dest_addr_i;
    logic        write_or_not_i;
    logic [31:0] wdata_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_sdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [4:0]  dest_addr_o;
    logic        write_or_not_o;
    logic [31:0] wdata_o;
    logic        stall_o;
    logic        misalign_o;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int unsigned stall_cnt;
    logic        cap_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    always #5 clk = ~clk;

    memory_access dut (
        .clk(clk), .rst(rst),
        .dest_addr_i(dest_addr_i), .write_or_not_i(write_or_not_i), .wdata_i(wdata_i),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .dest_addr_o(dest_addr_o), .write_or_not_o(write_or_not_o), .wdata_o(wdata_o),
        .stall_o(stall_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one memory op from IDLE through ACCESS, acking after `waits` idle
    // ACCESS cycles, and returns with the DUT in DONE.
    task automatic access(input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int unsigned waits);
        mem_op_i    = op;
        mem_addr_i  = addr;
        mem_sdata_i = sdata;
        #1;
        stall_cnt = 0;
        if (stall_o) stall_cnt++;
        tick();
        cap_req   = mem_req_o;
        cap_we    = mem_we_o;
        cap_addr  = mem_addr_o;
        cap_be    = mem_be_o;
        cap_wdata = mem_wdata_o;
        for (int unsigned w = 0; w < waits; w++) begin
            if (stall_o) stall_cnt++;
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        #1;
        if (stall_o) stall_cnt++;
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        #1;
    endtask

    task automatic retire();
        tick();
        mem_op_i = 4'd0;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        dest_addr_i = '0; write_or_not_i = 1'b0; wdata_i = '0;
        mem_op_i = '0; mem_addr_i = '0; mem_sdata_i = '0;
        mem_rdata_i = '0; mem_ack_i = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'b0, mem_req_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_misalign", {31'b0, misalign_o}, 32'd0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        dest_addr_i = 5'd5; write_or_not_i = 1'b1; wdata_i = 32'h1234;
        #1;
        chk("pt_dest", {27'b0, dest_addr_o}, 32'd5);
        chk("pt_we", {31'b0, write_or_not_o}, 32'd1);
        chk("pt_wdata", wdata_o, 32'h1234);
        chk("pt_stall", {31'b0, stall_o}, 32'd0);
        chk("pt_req", {31'b0, mem_req_o}, 32'd0);
        tick();

        // LW with two wait cycles
        dest_addr_i = 5'd8; wdata_i = 32'h55;
        access(4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 2);
        chk("lw_req", {31'b0, cap_req}, 32'd1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", {28'b0, cap_be}, 32'hF);
        chk("lw_memwe", {31'b0, cap_we}, 32'd0);
        chk("lw_stall_cycles", stall_cnt, 32'd4);
        chk("lw_done_stall", {31'b0, stall_o}, 32'd0);
        chk("lw_done_req", {31'b0, mem_req_o}, 32'd0);
        chk("lw_done_wdata", wdata_o, 32'hDEADBEEF);
        chk("lw_done_we", {31'b0, write_or_not_o}, 32'd1);
        chk("lw_done_dest", {27'b0, dest_addr_o}, 32'd8);
        retire();
        chk("lw_back_idle", {31'b0, stall_o}, 32'd0);
        tick();

        // LB / LBU at offset 3
        access(4'd1, 32'h103, 32'h0, 32'h000000F0, 0);
        chk("lb_be", {28'b0, cap_be}, 32'h1);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_stall_cycles", stall_cnt, 32'd2);
        chk("lb_wdata", wdata_o, 32'hFFFFFFF0);
        retire();
        tick();
        access(4'd2, 32'h103, 32'h0, 32'h000000F0, 0);
        chk("lbu_wdata", wdata_o, 32'h000000F0);
        retire();
        tick();

        // LH at offset 0, sign-extended
        access(4'd3, 32'h300, 32'h0, 32'h8001FFFF, 1);
        chk("lh_be", {28'b0, cap_be}, 32'hC);
        chk("lh_wdata", wdata_o, 32'hFFFF8001);
        retire();
        tick();

        // SH at offset 2
        access(4'd7, 32'h202, 32'hABCD1234, 32'h0, 0);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_be", {28'b0, cap_be}, 32'h3);
        chk("sh_mwdata", cap_wdata, 32'h12341234);
        chk("sh_memwe", {31'b0, cap_we}, 32'd1);
        chk("sh_done_we", {31'b0, write_or_not_o}, 32'd0);
        retire();
        tick();

        // SB at offset 1
        access(4'd6, 32'h401, 32'h000000A5, 32'h0, 0);
        chk("sb_be", {28'b0, cap_be}, 32'h4);
        chk("sb_mwdata", cap_wdata, 32'hA5A5A5A5);
        retire();
        tick();

        // Misaligned LW
        mem_op_i = 4'd5; mem_addr_i = 32'h101;
        #1;
        chk("mis_flag", {31'b0, misalign_o}, 32'd1);
        chk("mis_req", {31'b0, mem_req_o}, 32'd0);
        chk("mis_stall", {31'b0, stall_o}, 32'd0);
        chk("mis_we", {31'b0, write_or_not_o}, 32'd0);
        tick();
        chk("mis_no_req_next", {31'b0, mem_req_o}, 32'd0);
        mem_op_i = 4'd0;
        tick();

        // Reset during ACCESS abandons the request; a late ack is ignored
        mem_op_i = 4'd5; mem_addr_i = 32'h100; wdata_i = 32'h77;
        tick();
        chk("rstacc_req", {31'b0, mem_req_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstacc_forced_req", {31'b0, mem_req_o}, 32'd0);
        tick();
        rst = 1'b0;
        mem_op_i = 4'd0;
        #1;
        chk("rstacc_idle_req", {31'b0, mem_req_o}, 32'd0);
        chk("rstacc_idle_stall", {31'b0, stall_o}, 32'd0);
        mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF;
        tick();
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        #1;
        chk("late_ack_req", {31'b0, mem_req_o}, 32'd0);
        chk("late_ack_wdata", wdata_o, 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
